// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: control-bus field layout, stage-depth limits and
// the per-edge stage action.
package pipe_stage_reg_pkg;

    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 4;

    // Control-bus field offsets and widths (LSB first, 12 bits total)
    localparam int unsigned OP_CODE_LSB    = 0;
    localparam int unsigned OP_CODE_W      = 6;
    localparam int unsigned FUNCT_CODE_LSB = 6;
    localparam int unsigned FUNCT_CODE_W   = 3;
    localparam int unsigned ALU_SRC_LSB    = 9;
    localparam int unsigned BRANCH_LSB     = 10;
    localparam int unsigned WORD_SIZE_LSB  = 11;
    localparam int unsigned CTRL_W         = 12;

    typedef enum logic [1:0] {
        CELL_HOLD = 2'd0,
        CELL_LOAD = 2'd1,
        CELL_KILL = 2'd2
    } cell_op_e;

    function automatic logic depth_ok(input int unsigned depth);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline slot holding {valid, ctrl, data}; loads, holds or is killed on
// the falling edge of the clock.
module pipe_stage_cell
    import pipe_stage_reg_pkg::*;
#(
    parameter int NB      = 32,
    parameter int NB_CTRL = 12
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_kill,
    input  logic               i_valid,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB-1:0]      i_data,
    output logic               o_valid,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB-1:0]      o_data
);

    logic               valid_q;
    logic [NB_CTRL-1:0] ctrl_q;
    logic [NB-1:0]      data_q;

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (i_kill) begin
            // Kill leaves the payload in place; only valid/ctrl are cleared
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (i_load) begin
            valid_q <= i_valid;
            ctrl_q  <= i_valid ? i_ctrl : '0;
            data_q  <= i_data;
        end
    end

    assign o_valid = valid_q;
    assign o_ctrl  = ctrl_q;
    assign o_data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Chain of DEPTH pipeline slots with step/stall/flush control and a saturating
// count of bubbles leaving the last slot.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int NB      = 32,
    parameter int NB_CTRL = 12,
    parameter int DEPTH   = 1,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB-1:0]      i_data,
    output logic               o_valid,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB-1:0]      o_data,
    output logic [NB_CNT-1:0]  o_bubble_count,
    output logic               o_busy
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be within 1..4");
    end

    cell_op_e act;
    logic     load;
    logic     kill;

    always_comb begin
        act = CELL_HOLD;
        if (i_step) begin
            if (i_flush) begin
                act = CELL_KILL;
            end else if (!i_stall) begin
                act = CELL_LOAD;
            end
        end
    end

    assign load = (act == CELL_LOAD);
    assign kill = (act == CELL_KILL);

    // Element 0 is the stage input; element k+1 is the output of stage k
    logic [DEPTH:0]     valid_chain;
    logic [NB_CTRL-1:0] ctrl_chain [DEPTH+1];
    logic [NB-1:0]      data_chain [DEPTH+1];

    assign valid_chain[0] = i_valid;
    assign ctrl_chain[0]  = i_ctrl;
    assign data_chain[0]  = i_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage_cell #(
            .NB      (NB),
            .NB_CTRL (NB_CTRL)
        ) u_cell (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_load  (load),
            .i_kill  (kill),
            .i_valid (valid_chain[k]),
            .i_ctrl  (ctrl_chain[k]),
            .i_data  (data_chain[k]),
            .o_valid (valid_chain[k+1]),
            .o_ctrl  (ctrl_chain[k+1]),
            .o_data  (data_chain[k+1])
        );
    end

    logic [NB_CNT-1:0] cnt_q;
    logic [NB_CNT-1:0] cnt_d;
    logic              bubble;

    // The last slot ends up invalid after a flush, or after an advance that
    // loads an invalid entry from its predecessor.
    assign bubble = kill || (load && !valid_chain[DEPTH-1]);

    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != {NB_CNT{1'b1}})) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_valid        = valid_chain[DEPTH];
    assign o_ctrl         = ctrl_chain[DEPTH];
    assign o_data         = data_chain[DEPTH];
    assign o_bubble_count = cnt_q;
    assign o_busy         = |valid_chain[DEPTH:1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (DEPTH=1, DEPTH=3, and a
// DEPTH=1 copy with a 2-bit bubble counter) driven from shared inputs.
module tb_pipe_stage_reg;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic        step = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic [11:0] ctrl = '0;
    logic [31:0] data = '0;

    logic        a_valid, b_valid, c_valid;
    logic [11:0] a_ctrl, b_ctrl, c_ctrl;
    logic [31:0] a_data, b_data, c_data;
    logic [15:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;
    logic        a_busy, b_busy, c_busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [11:0] ctrl;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.NB(32), .NB_CTRL(12), .DEPTH(1), .NB_CNT(16)) u_d1 (
        .i_clk(clk), .i_reset(rst), .i_step(step), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_ctrl(ctrl), .i_data(data),
        .o_valid(a_valid), .o_ctrl(a_ctrl), .o_data(a_data),
        .o_bubble_count(a_cnt), .o_busy(a_busy)
    );

    pipe_stage_reg #(.NB(32), .NB_CTRL(12), .DEPTH(3), .NB_CNT(16)) u_d3 (
        .i_clk(clk), .i_reset(rst), .i_step(step), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_ctrl(ctrl), .i_data(data),
        .o_valid(b_valid), .o_ctrl(b_ctrl), .o_data(b_data),
        .o_bubble_count(b_cnt), .o_busy(b_busy)
    );

    pipe_stage_reg #(.NB(32), .NB_CTRL(12), .DEPTH(1), .NB_CNT(2)) u_c2 (
        .i_clk(clk), .i_reset(rst), .i_step(step), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_ctrl(ctrl), .i_data(data),
        .o_valid(c_valid), .o_ctrl(c_ctrl), .o_data(c_data),
        .o_bubble_count(c_cnt), .o_busy(c_busy)
    );

    // Active edge is the falling edge; sample 1 time unit after it
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b0; ctrl = '0; data = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step = 1'b1; valid = 1'b1; ctrl = 12'hFFF; data = 32'hDEAD_BEEF;
        tick();
        n_vec++; if (a_valid !== 1'b0 || a_ctrl !== 12'h0 || a_data !== 32'h0)
            begin n_err++; $display("FAIL reset_d1: got v=%b c=%h d=%h want 0/000/0", a_valid, a_ctrl, a_data); end
        n_vec++; if (b_valid !== 1'b0 || b_busy !== 1'b0 || b_data !== 32'h0 || b_cnt !== 16'd0)
            begin n_err++; $display("FAIL reset_d3: got v=%b busy=%b d=%h cnt=%0d want all 0", b_valid, b_busy, b_data, b_cnt); end
        n_vec++; if (c_cnt !== 2'd0)
            begin n_err++; $display("FAIL reset_cnt: got %0d want 0", c_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        step = 1'b1; valid = 1'b1; ctrl = 12'h123; data = 32'h0000_00AA;
        tick();
        n_vec++; if (a_valid !== 1'b1 || a_ctrl !== 12'h123 || a_data !== 32'hAA)
            begin n_err++; $display("FAIL single_load: got v=%b c=%h d=%h want 1/123/000000aa", a_valid, a_ctrl, a_data); end
        n_vec++; if (a_cnt !== 16'd0)
            begin n_err++; $display("FAIL single_cnt: got %0d want 0", a_cnt); end
        valid = 1'b0; ctrl = 12'h5A5; data = 32'h0000_0077;
        tick();
        n_vec++; if (a_valid !== 1'b0 || a_ctrl !== 12'h000 || a_data !== 32'h77)
            begin n_err++; $display("FAIL invalid_load: got v=%b c=%h d=%h want 0/000/00000077", a_valid, a_ctrl, a_data); end
        n_vec++; if (a_cnt !== 16'd1)
            begin n_err++; $display("FAIL invalid_cnt: got %0d want 1", a_cnt); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic want_v;
        do_reset();
        sb.delete();
        step = 1'b1;
        for (int ed = 1; ed <= 6; ed++) begin
            if (ed <= 3) begin
                valid = 1'b1; ctrl = 12'h100 + 12'(ed); data = 32'hA000_0000 + 32'(ed);
                e.ctrl = ctrl; e.data = data;
                sb.push_back(e);
            end else begin
                valid = 1'b0; ctrl = 12'h7FF; data = $urandom;
            end
            tick();
            want_v = (ed >= 3 && ed <= 5);
            n_vec++; if (b_valid !== want_v)
                begin n_err++; $display("FAIL b2b_valid edge %0d: got %b want %b", ed, b_valid, want_v); end
            if (b_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++; $display("FAIL b2b_extra edge %0d: got output d=%h want none", ed, b_data);
                end else begin
                    e = sb.pop_front();
                    n_vec++; if (b_data !== e.data || b_ctrl !== e.ctrl)
                        begin n_err++; $display("FAIL b2b_entry edge %0d: got c=%h d=%h want c=%h d=%h", ed, b_ctrl, b_data, e.ctrl, e.data); end
                end
            end
        end
        n_vec++; if (sb.size() != 0)
            begin n_err++; $display("FAIL b2b_drain: got %0d left want 0", sb.size()); end
        n_vec++; if (b_cnt !== 16'd3)
            begin n_err++; $display("FAIL b2b_cnt: got %0d want 3", b_cnt); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        step = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; ctrl = 12'h200 + 12'(i); data = 32'hB000_0000 + 32'(i);
            tick();
        end
        stall = 1'b1; valid = 1'b1; ctrl = 12'hEEE; data = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++; if (b_valid !== 1'b1 || b_ctrl !== 12'h200 || b_data !== 32'hB000_0000 || b_cnt !== 16'd2)
                begin n_err++; $display("FAIL stall_hold %0d: got v=%b c=%h d=%h cnt=%0d want 1/200/b0000000/2", i, b_valid, b_ctrl, b_data, b_cnt); end
        end
        stall = 1'b0; valid = 1'b0;
        tick();
        n_vec++; if (b_valid !== 1'b1 || b_data !== 32'hB000_0001 || b_cnt !== 16'd2)
            begin n_err++; $display("FAIL stall_release: got v=%b d=%h cnt=%0d want 1/b0000001/2", b_valid, b_data, b_cnt); end
        stall = 1'b1; flush = 1'b1; valid = 1'b1; ctrl = 12'h333;
        tick();
        n_vec++; if (b_valid !== 1'b0 || b_ctrl !== 12'h000 || b_data !== 32'hB000_0001 || b_cnt !== 16'd3 || b_busy !== 1'b0)
            begin n_err++; $display("FAIL flush_stall: got v=%b c=%h d=%h cnt=%0d busy=%b want 0/000/b0000001/3/0", b_valid, b_ctrl, b_data, b_cnt, b_busy); end
        stall = 1'b0; flush = 1'b0; valid = 1'b0;
    endtask

    task automatic test_step_hold();
        do_reset();
        step = 1'b1; valid = 1'b1; ctrl = 12'h0AB; data = 32'h1111_0000;
        tick();
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = i[0]; ctrl = 12'(i * 7); data = $urandom;
            tick();
            n_vec++; if (a_valid !== 1'b1 || a_ctrl !== 12'h0AB || a_data !== 32'h1111_0000 || a_cnt !== 16'd0)
                begin n_err++; $display("FAIL step_hold_d1 %0d: got v=%b c=%h d=%h cnt=%0d want 1/0ab/11110000/0", i, a_valid, a_ctrl, a_data, a_cnt); end
            n_vec++; if (b_valid !== 1'b0 || b_busy !== 1'b1 || b_cnt !== 16'd1)
                begin n_err++; $display("FAIL step_hold_d3 %0d: got v=%b busy=%b cnt=%0d want 0/1/1", i, b_valid, b_busy, b_cnt); end
        end
        step = 1'b1; valid = 1'b1; ctrl = 12'h0CD; data = 32'h2222_0000;
        tick();
        n_vec++; if (a_data !== 32'h2222_0000 || a_ctrl !== 12'h0CD || b_valid !== 1'b0)
            begin n_err++; $display("FAIL step_one: got d1=%h c1=%h d3v=%b want 22220000/0cd/0", a_data, a_ctrl, b_valid); end
        valid = 1'b0;
        tick();
        n_vec++; if (b_valid !== 1'b1 || b_data !== 32'h1111_0000 || b_ctrl !== 12'h0AB)
            begin n_err++; $display("FAIL step_slot: got v=%b c=%h d=%h want 1/0ab/11110000", b_valid, b_ctrl, b_data); end
    endtask

    task automatic test_saturate_reset();
        do_reset();
        step = 1'b1; valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_vec++; if (c_cnt !== 2'((i > 3) ? 3 : i))
                begin n_err++; $display("FAIL sat_cnt edge %0d: got %0d want %0d", i, c_cnt, (i > 3) ? 3 : i); end
        end
        valid = 1'b1; ctrl = 12'h055; data = 32'h55;
        tick();
        n_vec++; if (c_valid !== 1'b1 || c_data !== 32'h55 || c_cnt !== 2'd3)
            begin n_err++; $display("FAIL sat_load: got v=%b d=%h cnt=%0d want 1/55/3", c_valid, c_data, c_cnt); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (c_valid !== 1'b0 || c_ctrl !== 12'h0 || c_data !== 32'h0 || c_cnt !== 2'd0 || c_busy !== 1'b0)
            begin n_err++; $display("FAIL async_reset: got v=%b c=%h d=%h cnt=%0d busy=%b want all 0", c_valid, c_ctrl, c_data, c_cnt, c_busy); end
        n_vec++; if (a_data !== 32'h0 || b_cnt !== 16'd0)
            begin n_err++; $display("FAIL async_reset_all: got d1=%h cnt3=%0d want 0/0", a_data, b_cnt); end
        rst = 1'b0;
        valid = 1'b1; ctrl = 12'h066; data = 32'h66;
        tick();
        n_vec++; if (c_valid !== 1'b1 || c_data !== 32'h66 || c_cnt !== 2'd0 || b_valid !== 1'b0 || b_cnt !== 16'd1)
            begin n_err++; $display("FAIL post_reset: got v=%b d=%h cnt=%0d d3v=%b cnt3=%0d want 1/66/0/0/1", c_valid, c_data, c_cnt, b_valid, b_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall_flush();
        test_step_hold();
        test_saturate_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameters SHALL be:
- NB, default 32, payload (data) width per stage.
- NB_CTRL, default 12, control-bus width (op/funct/alu_src/branch/word_size packed).
- DEPTH, default 1, number of chained stages, legal range 1..4.
- NB_CNT, default 16, bubble-counter width.
REQ-002 Clock and reset SHALL be:
- i_clk, in, 1, single clock.
- i_reset, in, 1, asynchronous active-high reset.
REQ-003 Inputs SHALL be:
- i_step, in, 1, advance enable (debug step / run).
- i_stall, in, 1, hold all stages.
- i_flush, in, 1, kill all stages (insert bubbles).
- i_valid, in, 1, incoming entry valid.
- i_ctrl, in, NB_CTRL, incoming control bits.
- i_data, in, NB, incoming payload.
REQ-004 Outputs SHALL be:
- o_valid, out, 1, last-stage valid.
- o_ctrl, out, NB_CTRL, last-stage control.
- o_data, out, NB, last-stage payload.
- o_bubble_count, out, NB_CNT, number of bubbles emitted.
- o_busy, out, 1, OR of all stage valid bits.

Function
REQ-005 All state SHALL update on the falling edge of i_clk, matching the pipeline register timing.
REQ-006 An edge SHALL be active only when i_step=1; with i_step=0 all state, including the counter, SHALL hold.
REQ-007 On an active edge, the priority SHALL be: i_flush > i_stall > advance.
REQ-008 On advance, stage 0 SHALL load {i_valid, i_ctrl, i_data} and stage k SHALL load stage k-1, for k = 1..DEPTH-1.
REQ-009 When an invalid entry is loaded, the control bits SHALL load as zero; the payload SHALL load i_data unchanged.
REQ-010 On stall, every stage SHALL hold valid, ctrl and data.
REQ-011 On flush, every stage SHALL clear valid and ctrl to 0 and hold data; i_valid on that edge SHALL be discarded.
REQ-012 The outputs SHALL be driven directly from the last stage (DEPTH-1), with no combinational path from any input.
REQ-013 Latency SHALL be DEPTH active, unstalled, unflushed edges from input to output.
REQ-014 o_bubble_count SHALL increment by 1 on each active edge where the last stage becomes or remains invalid after an advance or flush.
REQ-015 o_bubble_count SHALL saturate at 2^NB_CNT-1 and never wrap.
REQ-016 o_bubble_count SHALL NOT increment on a stall.
REQ-017 Simultaneous i_stall=1 and i_flush=1 SHALL act as a flush.
REQ-018 A DEPTH value outside 1..4 SHALL fail elaboration.

Reset
REQ-019 While i_reset=1, the block SHALL asynchronously force every stage valid=0, ctrl=0 and data=0, and set o_bubble_count=0, independent of i_clk and i_step.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight entries; the first active edge after deassertion SHALL behave as an advance from an empty pipe.

Structure
REQ-021 NB_CTRL field offsets (op_code, funct_code, alu_src, branch, word_size) and the DEPTH limits SHALL live in the shared pipeline package.
REQ-022 A single-stage sub-module, pipe_stage_cell, SHALL hold one {valid, ctrl, data} entry with load/hold/kill controls.
REQ-023 The top level SHALL instantiate DEPTH copies of pipe_stage_cell in a generate loop and own the bubble counter.

Verification
REQ-024 Directed scenarios SHALL cover:
- DEPTH=1: i_valid=1, i_data=0x0000_00AA, i_ctrl=0x123, one active edge -> o_valid=1, o_data=0xAA, o_ctrl=0x123.
- DEPTH=3: three entries A,B,C on consecutive edges -> A appears on the 3rd edge, C on the 5th, with no gaps.
- i_stall=1 for 2 edges with the pipe full -> outputs unchanged, o_bubble_count unchanged.
- i_flush=1 with i_stall=1 on the same edge -> o_valid=0, o_ctrl=0, o_bubble_count +1.
- i_step=0 while toggling i_valid and i_data for 5 edges -> no output change; then one i_step=1 edge -> advance exactly one slot.
- NB_CNT=2 with an idle pipe for 5 active edges -> o_bubble_count=3; then async i_reset pulse between clock edges -> all outputs 0 immediately.
